// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of producers onto the
// register-file write port, plus a per-register pending-write scoreboard.
module regfile_wb_scheduler #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*5-1:0]    src_rd,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  output logic                    issue_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             busy,
  output logic [1:0]              err
);

  localparam int IW = (NUM_SRC > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [IW-1:0]      r_last;
  logic               r_we;
  logic [4:0]         r_waddr;
  logic [XLEN-1:0]    r_wdata;
  logic [1:0]         r_err;
  logic [CNT_W-1:0]   r_cnt [32];

  logic [NUM_SRC-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_found;
  logic [4:0]         w_rd;
  logic [XLEN-1:0]    w_data;
  logic               w_xfer;
  logic               w_dec;
  logic               w_inc;
  logic               w_same;
  logic               w_sat;

  // Search starts one past the last granted source and wraps.
  always_comb begin : p_arb
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    w_gnt   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = (int'(r_last) + k) % NUM_SRC;
      if (!w_found && src_valid[j]) begin
        w_found = 1'b1;
        w_idx   = IW'(j);
      end
    end
    if (w_found)
      w_gnt[w_idx] = 1'b1;
  end

  assign src_ready = w_gnt & {NUM_SRC{rst_n}};
  assign w_xfer    = |(src_valid & src_ready);
  assign w_rd      = src_rd[int'(w_idx)*5 +: 5];
  assign w_data    = src_data[int'(w_idx)*XLEN +: XLEN];

  assign w_sat       = (issue_rd != 5'd0) && (r_cnt[issue_rd] == CMAX);
  assign issue_ready = rst_n & ~w_sat;

  assign w_inc  = issue_valid & issue_ready & (issue_rd != 5'd0);
  assign w_dec  = w_xfer & (w_rd != 5'd0);
  assign w_same = w_inc & w_dec & (w_rd == issue_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= '0;
      r_last  <= IW'(NUM_SRC - 1);
      for (int r = 0; r < 32; r++)
        r_cnt[r] <= '0;
    end else begin
      r_we <= w_dec;
      if (w_dec) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
      if (w_xfer)
        r_last <= w_idx;
      if (w_inc && !w_same)
        r_cnt[issue_rd] <= r_cnt[issue_rd] + CNT_W'(1);
      // Underflow still writes the RF but pins the counter at zero.
      if (w_dec && !w_same) begin
        if (r_cnt[w_rd] == '0)
          r_err[0] <= 1'b1;
        else
          r_cnt[w_rd] <= r_cnt[w_rd] - CNT_W'(1);
      end
      if (issue_valid && w_sat)
        r_err[1] <= 1'b1;
    end
  end

  assign busy[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_busy
    assign busy[r] = (r_cnt[r] != '0);
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign err      = r_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a random run
// checked against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;

  localparam int N   = 3;
  localparam int XL  = 32;
  localparam int MAX = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N*5-1:0]  src_rd;
  logic [N*XL-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XL-1:0]   rf_wdata;
  logic [31:0]     busy;
  logic [1:0]      err;

  int checks;
  int errors;

  int          m_cnt [32];
  logic [1:0]  m_err;
  int          m_last;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  regfile_wb_scheduler #(.NUM_SRC(N), .XLEN(XL), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant(logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant(src_valid);
    if (rst_n && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_iready();
    return rst_n && (issue_rd == 0 || m_cnt[issue_rd] < MAX);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  task automatic tick();
    int g;
    logic [4:0] rd;
    logic [31:0] d;
    bit inc, dec, same;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0; m_last = N - 1;
      m_we = 0; m_waddr = 0; m_wdata = 0;
    end else begin
      g = model_grant(src_valid);
      rd = 0; d = 0;
      if (g >= 0) begin
        rd = src_rd[g*5 +: 5];
        d  = src_data[g*XL +: XL];
      end
      dec = (g >= 0) && rd != 0;
      inc = issue_valid && issue_rd != 0 && m_cnt[issue_rd] < MAX;
      if (issue_valid && issue_rd != 0 && m_cnt[issue_rd] == MAX)
        m_err[1] = 1'b1;
      same = inc && dec && rd == issue_rd;
      if (!same) begin
        if (inc) m_cnt[issue_rd]++;
        if (dec) begin
          if (m_cnt[rd] == 0) m_err[0] = 1'b1;
          else m_cnt[rd]--;
        end
      end
      m_we = dec;
      if (dec) begin
        m_waddr = rd;
        m_wdata = d;
      end
      if (g >= 0) m_last = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_valid = '0; issue_valid = 0; issue_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic set_src(int i, logic [4:0] rd, logic [31:0] d);
    src_rd[i*5 +: 5]   = rd;
    src_data[i*XL +: XL] = d;
  endtask

  task automatic test_reset();
    rst_n = 0;
    src_valid = '1; issue_valid = 1; issue_rd = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (src_ready !== 3'b000 || issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: src_ready=%b issue_ready=%b want 000/0",
                 src_ready, issue_ready);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0 || busy !== 32'd0 || err !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: we=%b busy=%h err=%b want 0/0/0",
                 rf_we, busy, err);
      end
    end
    rst_n = 1; issue_valid = 0;
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 001", src_ready);
    end
    idle();
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] seq [6];
    seq = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
    do_reset();
    set_src(0, 5'd5, 32'hA);
    set_src(1, 5'd6, 32'hB);
    set_src(2, 5'd7, 32'hC);
    src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (src_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b want %b", c, src_ready, exp_ready());
      end
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== seq[c]
          || rf_wdata !== 32'(seq[c]) + 32'd5) begin
        errors++;
        $display("FAIL rr_write[%0d]: we=%b addr=%0d data=%h want 1/%0d/%h",
                 c, rf_we, rf_waddr, rf_wdata, seq[c], 32'(seq[c]) + 32'd5);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    tick();
    idle();
    tick();
    checks++;
    if (busy[9] !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue2: busy9=%b want 1", busy[9]);
    end
    set_src(0, 5'd9, 32'h1234);
    src_valid = 3'b001;
    tick();
    idle();
    checks++;
    if (busy[9] !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      errors++;
      $display("FAIL sb_wb1: busy9=%b we=%b addr=%0d want 1/1/9",
               busy[9], rf_we, rf_waddr);
    end
    src_valid = 3'b001; issue_valid = 1; issue_rd = 5'd9;
    tick();
    idle();
    tick();
    checks++;
    if (busy[9] !== 1'b1 || err !== 2'b00) begin
      errors++;
      $display("FAIL sb_same_cycle: busy9=%b err=%b want 1/00", busy[9], err);
    end
    src_valid = 3'b001;
    tick();
    idle();
    checks++;
    if (busy[9] !== 1'b0 || err !== 2'b00) begin
      errors++;
      $display("FAIL sb_wb_last: busy9=%b err=%b want 0/00", busy[9], err);
    end
  endtask

  task automatic test_x0();
    logic [31:0] b0;
    do_reset();
    issue_valid = 1; issue_rd = 5'd12;
    tick();
    idle();
    b0 = busy;
    set_src(1, 5'd0, 32'hFFFF_FFFF);
    src_valid = 3'b010;
    #1;
    checks++;
    if (src_ready !== 3'b010) begin
      errors++;
      $display("FAIL x0_ready: got %b want 010", src_ready);
    end
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b0 || busy !== b0 || err !== 2'b00) begin
      errors++;
      $display("FAIL x0_wb: we=%b busy=%h err=%b want 0/%h/00",
               rf_we, busy, err, b0);
    end
    issue_valid = 1; issue_rd = 5'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_issue_ready: got %b want 1", issue_ready);
    end
    tick();
    idle();
    checks++;
    if (busy !== b0) begin
      errors++;
      $display("FAIL x0_issue: busy=%h want %h", busy, b0);
    end
  endtask

  task automatic test_sat_underflow();
    do_reset();
    issue_valid = 1; issue_rd = 5'd3;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (issue_ready !== (c < 3)) begin
        errors++;
        $display("FAIL sat_ready[%0d]: got %b want %b", c, issue_ready, c < 3);
      end
      tick();
    end
    idle();
    checks++;
    if (err !== 2'b10 || busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_err: err=%b busy3=%b want 10/1", err, busy[3]);
    end
    set_src(2, 5'd4, 32'hCAFE_0004);
    src_valid = 3'b100;
    tick();
    idle();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hCAFE_0004
        || err !== 2'b11 || busy[4] !== 1'b0) begin
      errors++;
      $display("FAIL uflow: we=%b addr=%0d data=%h err=%b busy4=%b want 1/4/cafe0004/11/0",
               rf_we, rf_waddr, rf_wdata, err, busy[4]);
    end
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (err !== 2'b11 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL uflow_sticky: err=%b we=%b want 11/0", err, rf_we);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1; issue_rd = 5'd8;
    set_src(0, 5'd10, 32'h10);
    src_valid = 3'b001;
    tick();
    tick();
    idle();
    set_src(1, 5'd8, 32'h88);
    src_valid = 3'b011;
    set_src(0, 5'd11, 32'h11);
    #1;
    checks++;
    if (src_ready !== 3'b010 || busy[8] !== 1'b1 || err[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: ready=%b busy8=%b err=%b want 010/1/x1",
               src_ready, busy[8], err);
    end
    rst_n = 0;
    #1;
    checks++;
    if (src_ready !== 3'b000) begin
      errors++;
      $display("FAIL mid_ready: got %b want 000", src_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || busy !== 32'd0 || err !== 2'd0) begin
      errors++;
      $display("FAIL mid_state: we=%b busy=%h err=%b want 0/0/0",
               rf_we, busy, err);
    end
    rst_n = 1;
    #1;
    checks++;
    if (src_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_ptr: got %b want 001", src_ready);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int g;
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] && $urandom_range(0, 2) == 0) begin
          set_src(i, 5'($urandom_range(0, 6)), $urandom);
          src_valid[i] = 1'b1;
        end
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom_range(0, 6));
      #1;
      checks++;
      if (src_ready !== exp_ready()
          || (issue_valid && issue_ready !== exp_iready())) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: ready=%b/%b want %b/%b",
                 c, src_ready, issue_ready, exp_ready(), exp_iready());
      end
      g = rst_n ? model_grant(src_valid) : -1;
      tick();
      if (g >= 0) src_valid[g] = 1'b0;
      checks++;
      if (rf_we !== m_we || busy !== exp_busy() || err !== m_err
          || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        errors++;
        $display("FAIL rnd_out[%0d]: we=%b a=%0d d=%h busy=%h err=%b want %b/%0d/%h/%h/%b",
                 c, rf_we, rf_waddr, rf_wdata, busy, err,
                 m_we, m_waddr, m_wdata, exp_busy(), m_err);
      end
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    src_rd = '0;
    src_data = '0;
    idle();
    rst_n = 0;
    m_last = N - 1;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_x0();
    test_sat_underflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler for the core's 32×32 integer register file. It shares the single register-file write port between `NUM_SRC` writeback producers (ALU, load unit, mul/div) using round-robin arbitration with valid/ready handshakes, and drives a registered write onto the register file. It also keeps a per-register pending-write scoreboard that issue logic uses to stall on read-after-write hazards.

## Interface
Parameters:
- `NUM_SRC`, 3: number of writeback requesters (2..4).
- `XLEN`, 32: data width.
- `CNT_W`, 2: width of the per-register pending-write counter.

Ports (one synchronous clock, active-low reset):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `src_valid`  in  NUM_SRC: source i has a write pending.
- `src_rd`  in  NUM_SRC×5: destination register of source i, packed with i·5 as the LSB.
- `src_data`  in  NUM_SRC×XLEN: write data of source i, packed.
- `src_ready`  out  NUM_SRC: combinational grant; a transfer happens when `src_valid[i] & src_ready[i]`.
- `issue_valid`  in  1: issue stage dispatches an instruction that will write `issue_rd`.
- `issue_rd`  in  5: destination of the dispatched instruction.
- `issue_ready`  out  1: dispatch accepted; low when `issue_rd`'s counter is saturated.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  5: register-file write address.
- `rf_wdata`  out  XLEN: register-file write data.
- `busy`  out  32: bit r is high while register r has at least one outstanding write; bit 0 is always 0.
- `err`  out  2: sticky errors. Bit 0 is scoreboard underflow. Bit 1 is an issue request made while the counter was saturated.

## Operation
- **Arbitration.**
  - Round-robin over sources with `src_valid` high.
  - The search starts at `last_grant+1` and wraps modulo `NUM_SRC`.
  - At most one `src_ready` bit is high per cycle, and only for a valid source.
  - `last_grant` updates only on a completed transfer.
- **Source rules.** A source must hold `src_valid`, `src_rd` and `src_data` stable until its transfer completes. `src_ready` never depends on anything but current `src_valid` and state.
- **Write path.**
  - A transfer with rd≠0 registers `rf_we=1`, `rf_waddr=rd` and `rf_wdata=data` for the next cycle.
  - A transfer with rd=0 is accepted and discarded: `rf_we=0` next cycle, and the scoreboard is untouched.
  - With no transfer, `rf_we=0`. `rf_waddr` and `rf_wdata` hold their previous values.
- **Scoreboard.**
  - Each register r≠0 has a `CNT_W`-bit counter `cnt[r]`.
  - An issue handshake (`issue_valid & issue_ready`, `issue_rd`≠0) increments `cnt[issue_rd]`.
  - A writeback transfer with rd≠0 decrements `cnt[rd]`.
  - If both hit the same register in the same cycle, the count is unchanged.
  - `busy[r] = (cnt[r]≠0)`. `busy` is derived from the registered counters, so it updates the cycle after the event.
- **issue_ready.**
  - `issue_ready = ~(cnt[issue_rd]==max)` when `issue_valid` is high.
  - An issue with `issue_rd=0` is always ready and has no effect.
  - A same-cycle decrement does not relieve saturation.
  - If `issue_valid` is high while saturated, `err[1]` sets.
- **Underflow.** A writeback to rd≠0 with `cnt[rd]==0`:
  - is still written to the register file;
  - leaves the counter at 0;
  - sets `err[0]`.

  The only exception is a simultaneous issue increment of the same rd in that cycle, which nets to 0 without error.
- **Error clearing.** `err` bits clear only on reset.

## Timing
- **Reset** (`rst_n=0` at an edge):
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`;
  - all `cnt=0`, so `busy=0`;
  - `err=0`;
  - `last_grant=NUM_SRC-1`, so source 0 wins first.
- **During reset** `src_ready=0` and `issue_ready=0`. No transfer or issue completes in a cycle where `rst_n` is low.
- **Reset mid-operation** discards in-flight grants and all counters. Sources must re-present their requests.
- **Write latency.** A transfer completing at edge N appears as `rf_we`/`rf_waddr`/`rf_wdata` during cycle N..N+1, and is committed to the register file at edge N+1.
- **Throughput.** One write per cycle. Back-to-back grants to the same source are allowed when it is the only valid source.
- **Starvation.** With k sources continuously valid, each is granted exactly once every k cycles.
- **busy timing.** `busy[rd]` clears at the same edge that registers the write. Consumers combine it with the register file's write-forwarding or wait one cycle.

## Test plan
- **Reset.** Hold `rst_n=0` for 3 cycles with all requests high. Required: `src_ready=0`, `issue_ready=0`, `rf_we=0`, `busy=0`, `err=0`. After release, source 0 is granted first.
- **Round-robin.** Sources 0, 1 and 2 are continuously valid with rd=5, 6, 7 and data 0xA, 0xB, 0xC. Required: `rf_waddr` sequence 5, 6, 7, 5, 6, 7 on consecutive cycles, each one cycle after its grant, with `rf_we=1` throughout.
- **Scoreboard counting.**
  - Issue rd=9 twice: `busy[9]=1` and `cnt=2`.
  - One writeback to x9: `busy[9]` stays 1.
  - Second writeback to x9: `busy[9]=0` on the next cycle.
  - Simultaneous issue and writeback to x9 at `cnt=1`: `cnt` stays 1.
- **x0 handling.** Writeback rd=0 with data 0xFFFFFFFF: `src_ready=1`, `rf_we=0` next cycle, `busy` unchanged. Issue with rd=0 and `issue_valid=1`: `issue_ready=1`, no counter change.
- **Saturation and underflow.**
  - Issue rd=3 four times with `CNT_W=2`: the 4th sees `issue_ready=0` and `err[1]=1`.
  - Writeback to rd=4 with `cnt[4]=0`: `rf_we=1`, `rf_waddr=4`, `err[0]=1`, and `err[0]` stays set until reset.
- **Reset mid-stream.** Assert `rst_n=0` while `cnt[8]=2` and source 1 is being granted. Required: the next cycle has `rf_we=0`, `busy=0`, `err=0`, and the grant pointer is back to source 0.
